alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 87 ++++++++
 tb/tb_alu_issue_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an RV32I ALU op into selector and operands and
// buffers it in a 2-entry skid buffer ahead of the execute unit.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        is_imm,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  sel,
    output logic [31:0] x,
    output logic [31:0] y
);

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] x;
        logic [31:0] y;
    } op_t;

    op_t  in_op;
    op_t  out_op;
    op_t  skid_op;
    logic skid_valid;
    logic accept;
    logic out_free;

    always_comb begin
        in_op.sel = 4'b0000;
        in_op.x   = rs1_val;
        in_op.y   = is_imm ? imm : rs2_val;
        unique case (1'b1)
            (funct3 == 3'b000): in_op.sel = (funct7_5 && !is_imm) ? 4'b0001 : 4'b0000;
            (funct3 == 3'b001): in_op.sel = 4'b0111;
            (funct3 == 3'b010): in_op.sel = 4'b0101;
            (funct3 == 3'b011): in_op.sel = 4'b0110;
            (funct3 == 3'b100): in_op.sel = 4'b0100;
            (funct3 == 3'b101): in_op.sel = funct7_5 ? 4'b1001 : 4'b1000;
            (funct3 == 3'b110): in_op.sel = 4'b0011;
            (funct3 == 3'b111): in_op.sel = 4'b0010;
            default:            in_op.sel = 4'b0000;
        endcase
    end

    // in_ready depends only on registered state to keep handshakes acyclic
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_op     <= '0;
            skid_op    <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_op     <= skid_op;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_op    <= in_op;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_op    <= in_op;
            skid_valid <= 1'b1;
        end
    end

    assign sel = out_op.sel;
    assign x   = out_op.x;
    assign y   = out_op.y;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a
// randomized run against a FIFO-of-depth-2 reference model.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        is_imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  sel;
    logic [31:0] x;
    logic [31:0] y;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] x;
        logic [31:0] y;
    } exp_t;

    exp_t q[$];

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .funct7_5(funct7_5), .is_imm(is_imm),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .x(x), .y(y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_sel(input logic [2:0] f3,
                                           input logic f7,
                                           input logic im);
        case (f3)
            3'd0:    return (f7 && !im) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] f3, input logic f7,
                         input logic im, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] i);
        in_valid = v;
        funct3   = f3;
        funct7_5 = f7;
        is_imm   = im;
        rs1_val  = a;
        rs2_val  = b;
        imm      = i;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sel !== 4'd0 ||
            x !== 32'd0 || y !== 32'd0) begin
            n_err++;
            $display("FAIL reset: out_valid=%b in_ready=%b sel=%h x=%h y=%h want 0 1 0 0 0",
                     out_valid, in_ready, sel, x, y);
        end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        drive(1, 3'd0, 1, 0, 32'd5, 32'd3, 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || sel !== 4'b0001 || x !== 32'd5 || y !== 32'd3) begin
            n_err++;
            $display("FAIL sub: v=%b sel=%h x=%0d y=%0d want 1 1 5 3",
                     out_valid, sel, x, y);
        end
        @(negedge clk);
    endtask

    task automatic test_imm();
        out_ready = 1'b1;
        drive(1, 3'd0, 1, 1, 32'd7, 32'd9, 32'hFFFF_FFFF);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || sel !== 4'b0000 || y !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL addi: v=%b sel=%h y=%h want 1 0 ffffffff", out_valid, sel, y);
        end
        drive(1, 3'd5, 1, 1, 32'h8000_0000, 32'd9, 32'd4);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || sel !== 4'b1001 || y !== 32'd4) begin
            n_err++;
            $display("FAIL srai: v=%b sel=%h y=%h want 1 9 4", out_valid, sel, y);
        end
        @(negedge clk);
    endtask

    task automatic test_decode();
        logic [3:0]  es;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] i;
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            a = $urandom;
            b = $urandom;
            i = $urandom;
            es = ref_sel(3'(k >> 2), k[1], k[0]);
            drive(1, 3'(k >> 2), k[1], k[0], a, b, i);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || sel !== es || x !== a ||
                y !== (k[0] ? i : b)) begin
                n_err++;
                $display("FAIL decode k=%0d: v=%b sel=%h x=%h y=%h want sel=%h x=%h y=%h",
                         k, out_valid, sel, x, y, es, a, k[0] ? i : b);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1, 3'd4, 0, 0, 32'hA, 32'hA0, 0);
        @(negedge clk);
        drive(1, 3'd6, 0, 0, 32'hB, 32'hB0, 0);
        @(negedge clk);
        drive(1, 3'd7, 0, 0, 32'hC, 32'hC0, 0);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || x !== 32'hA || sel !== 4'd4) begin
            n_err++;
            $display("FAIL b2b_full: in_ready=%b v=%b x=%h sel=%h want 0 1 a 4",
                     in_ready, out_valid, x, sel);
        end
        @(negedge clk);
        n_cmp++;
        if (x !== 32'hA || y !== 32'hA0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_hold: x=%h y=%h in_ready=%b want a a0 0", x, y, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || x !== 32'hB || sel !== 4'd3) begin
            n_err++;
            $display("FAIL b2b_B: v=%b x=%h sel=%h want 1 b 3", out_valid, x, sel);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || x !== 32'hC || y !== 32'hC0 || sel !== 4'd2) begin
            n_err++;
            $display("FAIL b2b_C: v=%b x=%h y=%h sel=%h want 1 c c0 2", out_valid, x, y, sel);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1, 3'd0, 0, 0, 32'h11, 0, 0);
        @(negedge clk);
        drive(1, 3'd0, 0, 0, 32'h22, 0, 0);
        @(negedge clk);
        drive(1, 3'd0, 0, 0, 32'h33, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_full: v=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        // offer accepted in the flush cycle itself must also vanish
        drive(1, 3'd0, 0, 0, 32'h44, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL flush_drop%0d: out_valid=%b x=%h want 0", k, out_valid, x);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1, 3'd1, 0, 0, 32'h55, 32'h66, 0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sel !== 4'd0 ||
            x !== 32'd0 || y !== 32'd0) begin
            n_err++;
            $display("FAIL async_rst: v=%b in_ready=%b sel=%h x=%h y=%h want 0 1 0 0 0",
                     out_valid, in_ready, sel, x, y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, 3'd2, 0, 0, 32'h77, 32'h88, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1 || x !== 32'h77 || sel !== 4'd5) begin
            n_err++;
            $display("FAIL rst_resume: v=%b x=%h sel=%h want 1 77 5", out_valid, x, sel);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t e;
        logic [2:0] f3;
        logic f7;
        logic im;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] i;
        logic v;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            n_cmp++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_err++;
                $display("FAIL rand_ctl c=%0d: v=%b in_ready=%b model_size=%0d",
                         c, out_valid, in_ready, q.size());
            end else if (q.size() > 0 &&
                         (sel !== q[0].sel || x !== q[0].x || y !== q[0].y)) begin
                n_err++;
                $display("FAIL rand_data c=%0d: sel=%h x=%h y=%h want %h %h %h",
                         c, sel, x, y, q[0].sel, q[0].x, q[0].y);
            end
            v  = ($urandom_range(0, 99) < 65);
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            im = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            i  = $urandom;
            drive(v, f3, f7, im, a, b, i);
            out_ready = ($urandom_range(0, 99) < 55);
            flush     = ($urandom_range(0, 99) < 4);
            if (flush) begin
                q.delete();
            end else begin
                logic can_take;
                can_take = (q.size() < 2);
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (v && can_take) begin
                    e.sel = ref_sel(f3, f7, im);
                    e.x   = a;
                    e.y   = im ? i : b;
                    q.push_back(e);
                end
            end
            @(negedge clk);
        end
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sub();
        test_imm();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
